// File: rtl/alu_operand_stage.sv
// Operand-fetch / writeback pipeline wrapped around the combinational alu.
// Optional feature macro: ALU_OPERAND_STAGE_FWD_EN (bypass from alu_out instead of a one-cycle stall).
module alu_operand_stage #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned REG_AW = 5,
    localparam int unsigned FN_W = 6,
    localparam int unsigned IMM_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FN_W-1:0]   in_alufn,
    input  logic [REG_AW-1:0] in_ra,
    input  logic [REG_AW-1:0] in_rb,
    input  logic [REG_AW-1:0] in_rc,
    input  logic              in_imm_sel,
    input  logic [IMM_W-1:0]  in_imm,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [FN_W-1:0]   alu_fn,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_z,
    input  logic              alu_v,
    input  logic              alu_n,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rc,
    output logic [WIDTH-1:0]  wb_data,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n
);

    localparam int unsigned NUM_REGS = 32;
    localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(31);

    logic [WIDTH-1:0]  rf [NUM_REGS];
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rc;

    logic              wr_en_c;
    logic              fire_c;
    logic [WIDTH-1:0]  rd_a_c;
    logic [WIDTH-1:0]  rd_b_c;
    logic [WIDTH-1:0]  opnd_b_c;

    assign wr_en_c = ex_valid && (ex_rc != ZERO_REG);
    assign fire_c  = in_valid && in_ready;

    // Read ports: R31 reads zero; a same-edge writeback is visible (write-through).
    always_comb begin
        rd_a_c = '0;
        rd_b_c = '0;
        if (in_ra != ZERO_REG) begin
            rd_a_c = (wr_en_c && (in_ra == ex_rc)) ? alu_out : rf[in_ra];
        end
        if (in_rb != ZERO_REG) begin
            rd_b_c = (wr_en_c && (in_rb == ex_rc)) ? alu_out : rf[in_rb];
        end
    end

    assign opnd_b_c = in_imm_sel ? WIDTH'($signed(in_imm)) : rd_b_c;

`ifdef ALU_OPERAND_STAGE_FWD_EN
    // The write-through path doubles as the bypass, so issue never stalls.
    assign in_ready = rst_n;
`else
    logic hazard_c;

    // Dependent source on the instruction in execute: hold it off for one cycle.
    assign hazard_c = in_valid && wr_en_c &&
                      ((in_ra == ex_rc) || (!in_imm_sel && (in_rb == ex_rc)));
    assign in_ready = rst_n && !hazard_c;
`endif

    // Stage 1: issue operands to the alu.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_fn   <= '0;
            ex_rc    <= '0;
            ex_valid <= 1'b0;
        end else begin
            ex_valid <= fire_c;
            if (fire_c) begin
                alu_a  <= rd_a_c;
                alu_b  <= opnd_b_c;
                alu_fn <= in_alufn;
                ex_rc  <= in_rc;
            end
        end
    end

    // Stage 2: capture result and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rc    <= '0;
            wb_data  <= '0;
            flag_z   <= 1'b0;
            flag_v   <= 1'b0;
            flag_n   <= 1'b0;
        end else begin
            wb_valid <= ex_valid;
            if (ex_valid) begin
                wb_rc   <= ex_rc;
                wb_data <= alu_out;
                flag_z  <= alu_z;
                flag_v  <= alu_v;
                flag_n  <= alu_n;
            end
        end
    end

    // Register file write port; R31 is never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en_c) begin
            rf[ex_rc] <= alu_out;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage with a behavioural alu stub and an
// architectural register-file reference model.
module tb_alu_operand_stage;

    localparam int unsigned W = 32;

    localparam logic [5:0] FN_ADD   = 6'h00;
    localparam logic [5:0] FN_SUB   = 6'h01;
    localparam logic [5:0] FN_XOR   = 6'h16;
    localparam logic [5:0] FN_AND   = 6'h18;
    localparam logic [5:0] FN_OR    = 6'h1E;
    localparam logic [5:0] FN_SHL   = 6'h20;
    localparam logic [5:0] FN_CMPLT = 6'h35;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [5:0]   fn;
    } op_t;

    typedef struct packed {
        logic [4:0]   rc;
        logic [W-1:0] data;
        logic         z;
        logic         v;
        logic         n;
    } wb_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   in_alufn;
    logic [4:0]   in_ra;
    logic [4:0]   in_rb;
    logic [4:0]   in_rc;
    logic         in_imm_sel;
    logic [15:0]  in_imm;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [5:0]   alu_fn;
    logic [W-1:0] alu_out;
    logic         alu_z;
    logic         alu_v;
    logic         alu_n;
    logic         wb_valid;
    logic [4:0]   wb_rc;
    logic [W-1:0] wb_data;
    logic         flag_z;
    logic         flag_v;
    logic         flag_n;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = -10;
    logic [4:0] last_rc = 5'd31;
    logic in_reset = 1'b1;

    logic [W-1:0] mrf [32];
    op_t op_q [$];
    wb_t wb_q [$];
    op_t cur_op = '0;
    wb_t cur_wb = '0;
    logic wb_due = 1'b0;

    alu_operand_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_alufn(in_alufn),
        .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
        .in_imm_sel(in_imm_sel), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn),
        .alu_out(alu_out), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
        .wb_valid(wb_valid), .wb_rc(wb_rc), .wb_data(wb_data),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
    );

    // Behavioural alu: returns {z, v, n, result}.
    function automatic logic [W+2:0] alu_model(input logic [5:0] fn, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [W-1:0] r;
        logic v;
        v = 1'b0;
        case (fn)
            FN_ADD: begin
                r = a + b;
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            FN_SUB: begin
                r = a - b;
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            FN_XOR:   r = a ^ b;
            FN_AND:   r = a & b;
            FN_OR:    r = a | b;
            FN_SHL:   r = a << b[4:0];
            FN_CMPLT: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default:  r = '0;
        endcase
        return {(r == '0), v, r[W-1], r};
    endfunction

    assign {alu_z, alu_v, alu_n, alu_out} = alu_model(alu_fn, alu_a, alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rd(input logic [4:0] r);
        return (r == 5'd31) ? '0 : mrf[r];
    endfunction

    // Drive one instruction, wait for acceptance, then record the expected behaviour.
    task automatic issue(input logic [5:0] fn, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] rc, input logic isel, input logic [15:0] imm,
                         output int waits);
        logic hz;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W+2:0] r;
        @(negedge clk);
        hz = (acc_cyc == cyc) && (last_rc != 5'd31) &&
             ((ra == last_rc) || (!isel && (rb == last_rc)));
        in_valid = 1'b1; in_alufn = fn; in_ra = ra; in_rb = rb; in_rc = rc;
        in_imm_sel = isel; in_imm = imm;
        waits = 0;
        #1;
        while (!in_ready && waits < 4) begin
            waits++;
            @(negedge clk);
            #1;
        end
        if (!in_ready) begin
            chk("ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
`ifdef ALU_OPERAND_STAGE_FWD_EN
        chk("stall_cycles", waits, 0);
`else
        chk("stall_cycles", waits, hz ? 1 : 0);
`endif
        @(posedge clk);
        a = rd(ra);
        b = isel ? {{16{imm[15]}}, imm} : rd(rb);
        r = alu_model(fn, a, b);
        if (rc != 5'd31) mrf[rc] = r[W-1:0];
        op_q.push_back('{a: a, b: b, fn: fn});
        wb_q.push_back('{rc: rc, data: r[W-1:0], z: r[W+2], v: r[W+1], n: r[W]});
        #1;
        in_valid = 1'b0;
        acc_cyc = cyc;
        last_rc = rc;
    endtask

    // Monitor: operands one cycle after acceptance, writeback one cycle later; both hold otherwise.
    always @(negedge clk) begin
        if (in_reset) begin
            op_q.delete();
            wb_q.delete();
            wb_due = 1'b0;
            cur_op = '0;
            cur_wb = '0;
        end else begin
            if (wb_due) begin
                if (wb_q.size() == 0) chk("wb_q_underflow", wb_q.size(), 1);
                else cur_wb = wb_q.pop_front();
            end
            chk("wb_valid", wb_valid, wb_due);
            chk("wb_rc", wb_rc, cur_wb.rc);
            chk("wb_data", wb_data, cur_wb.data);
            chk("flags_zvn", {flag_z, flag_v, flag_n}, {cur_wb.z, cur_wb.v, cur_wb.n});
            wb_due = 1'b0;
            if (op_q.size() != 0) begin
                cur_op = op_q.pop_front();
                wb_due = 1'b1;
            end
            chk("alu_a", alu_a, cur_op.a);
            chk("alu_b", alu_b, cur_op.b);
            chk("alu_fn", alu_fn, cur_op.fn);
        end
    end

    initial begin
        int w;
        int pick;
        logic [5:0] fns [7];
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] rc;
        fns = '{FN_ADD, FN_SUB, FN_XOR, FN_AND, FN_OR, FN_SHL, FN_CMPLT};
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        rst_n = 1'b0; in_valid = 1'b0; in_alufn = '0; in_ra = '0; in_rb = '0; in_rc = '0;
        in_imm_sel = 1'b0; in_imm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_wb_valid", wb_valid, 0);
        chk("reset_alu_a", alu_a, 0);
        rst_n = 1'b1;
        @(posedge clk);
        in_reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);

        // ADD R1 <- R31 + 0x1234
        issue(FN_ADD, 5'd31, 5'd0, 5'd1, 1'b1, 16'h1234, w);
        @(negedge clk);
        chk("t1_alu_a", alu_a, 0);
        chk("t1_alu_b", alu_b, 32'h0000_1234);
        @(negedge clk);
        chk("t1_wb_valid", wb_valid, 1);
        chk("t1_wb_rc", wb_rc, 1);
        chk("t1_wb_data", wb_data, 32'h0000_1234);

        // Negative immediate sign extension
        issue(FN_ADD, 5'd31, 5'd0, 5'd2, 1'b1, 16'h8000, w);
        @(negedge clk);
        chk("t2_alu_b", alu_b, 32'hFFFF_8000);
        @(negedge clk);
        chk("t2_wb_data", wb_data, 32'hFFFF_8000);
        chk("t2_flag_n", flag_n, 1);

        // Back-to-back dependency
        issue(FN_ADD, 5'd31, 5'd0, 5'd1, 1'b1, 16'h1234, w);
        issue(FN_ADD, 5'd1, 5'd1, 5'd3, 1'b0, 16'h0000, w);
`ifdef ALU_OPERAND_STAGE_FWD_EN
        chk("t3_stall", w, 0);
`else
        chk("t3_stall", w, 1);
`endif
        @(negedge clk);
        @(negedge clk);
        chk("t3_wb_data", wb_data, 32'h0000_2468);

        // SUB to zero, then signed compare
        issue(FN_SUB, 5'd1, 5'd1, 5'd4, 1'b0, 16'h0000, w);
        @(negedge clk);
        @(negedge clk);
        chk("t4_wb_data", wb_data, 0);
        chk("t4_flag_z", flag_z, 1);
        issue(FN_ADD, 5'd31, 5'd0, 5'd5, 1'b1, 16'h0872, w);
        issue(FN_SHL, 5'd5, 5'd0, 5'd5, 1'b1, 16'd16, w);
        issue(FN_ADD, 5'd5, 5'd0, 5'd5, 1'b1, 16'hABCD, w);
        issue(FN_ADD, 5'd31, 5'd0, 5'd6, 1'b1, 16'h0A72, w);
        issue(FN_SHL, 5'd6, 5'd0, 5'd6, 1'b1, 16'd16, w);
        issue(FN_ADD, 5'd6, 5'd0, 5'd6, 1'b1, 16'hABCD, w);
        issue(FN_CMPLT, 5'd5, 5'd6, 5'd7, 1'b0, 16'h0000, w);
        @(negedge clk);
        chk("t5_alu_a", alu_a, 32'h0871_ABCD);
        chk("t5_alu_b", alu_b, 32'h0A71_ABCD);
        @(negedge clk);
        chk("t5_wb_data", wb_data, 1);
        chk("t5_flag_z", flag_z, 0);

        // R31 destination
        issue(FN_ADD, 5'd31, 5'd0, 5'd31, 1'b1, 16'h7FFF, w);
        @(negedge clk);
        @(negedge clk);
        chk("t6_wb_valid", wb_valid, 1);
        chk("t6_wb_rc", wb_rc, 31);
        chk("t6_wb_data", wb_data, 32'h0000_7FFF);
        issue(FN_ADD, 5'd31, 5'd31, 5'd8, 1'b0, 16'h0000, w);
        @(negedge clk);
        chk("t6_alu_a_r31", alu_a, 0);

        // Reset while an instruction is in stage 2
        issue(FN_ADD, 5'd31, 5'd0, 5'd1, 1'b1, 16'h5555, w);
        @(negedge clk);
        rst_n = 1'b0;
        in_reset = 1'b1;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        in_valid = 1'b1;
        #1;
        chk("t7_ready_in_reset", in_ready, 0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t7_wb_valid", wb_valid, 0);
        chk("t7_wb_data", wb_data, 0);
        chk("t7_wb_rc", wb_rc, 0);
        chk("t7_alu_a", alu_a, 0);
        chk("t7_alu_b", alu_b, 0);
        chk("t7_flags", {flag_z, flag_v, flag_n}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        in_reset = 1'b0;
        issue(FN_ADD, 5'd1, 5'd31, 5'd9, 1'b0, 16'h0000, w);
        @(negedge clk);
        chk("t7_r1_after_reset", alu_a, 0);

        // Random traffic over a small register set to provoke dependencies
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_ra = 5'($urandom); in_rb = 5'($urandom); in_rc = 5'($urandom);
                in_imm_sel = 1'($urandom);
                @(posedge clk);
            end else begin
                pick = $urandom_range(0, 4);
                ra = (pick == 4) ? 5'd31 : 5'(pick);
                pick = $urandom_range(0, 4);
                rb = (pick == 4) ? 5'd31 : 5'(pick);
                pick = $urandom_range(0, 4);
                rc = (pick == 4) ? 5'd31 : 5'(pick);
                issue(fns[$urandom_range(0, 6)], ra, rb, rc, 1'($urandom), 16'($urandom), w);
            end
        end
        repeat (4) @(negedge clk);
        chk("op_q_drained", op_q.size(), 0);
        chk("wb_q_drained", wb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
